// File: rtl/fmdll_sel_seq.sv
// Sequences the DLL reference/feedback/hold-low mux select over an N x M frame.
// A frame is M groups of N cycles; the N and M ratios are only reloaded at a frame wrap.
module fmdll_sel_seq #(
  parameter int unsigned NW = 4,
  parameter int unsigned MW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          stop,
  input  logic [NW-1:0] n_cfg,
  input  logic [MW-1:0] m_cfg,
  input  logic          clk_out_lvl,
  output logic [1:0]    sel,
  output logic [NW-1:0] n_cnt,
  output logic [MW-1:0] m_cnt,
  output logic          frame_done,
  output logic          cfg_err,
  output logic          busy
);

  localparam logic [1:0] SelInject   = 2'b00;
  localparam logic [1:0] SelFeedback = 2'b10;
  localparam logic [1:0] SelHoldLow  = 2'b01;

  typedef enum logic {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [NW-1:0]   n_act_q, n_act_d;
  logic [MW-1:0]   m_act_q, m_act_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [MW-1:0]   m_cnt_q, m_cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic            frame_done_q, frame_done_d;
  logic            cfg_err_q, cfg_err_d;

  logic n_wrap, m_wrap, cfg_ok;

  assign n_wrap = (n_cnt_q == n_act_q);
  assign m_wrap = (m_cnt_q == m_act_q);
  assign cfg_ok = (n_cfg != '0) && (m_cfg != '0);

  always_comb begin
    state_d      = state_q;
    n_act_d      = n_act_q;
    m_act_d      = m_act_q;
    n_cnt_d      = n_cnt_q;
    m_cnt_d      = m_cnt_q;
    sel_d        = sel_q;
    frame_done_d = 1'b0;
    cfg_err_d    = cfg_err_q;

    if (stop) begin
      state_d = StIdle;
      n_cnt_d = '0;
      m_cnt_d = '0;
      sel_d   = SelInject;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en) begin
            if (cfg_ok) begin
              state_d   = StRun;
              n_act_d   = n_cfg;
              m_act_d   = m_cfg;
              n_cnt_d   = NW'(1);
              m_cnt_d   = MW'(1);
              cfg_err_d = 1'b0;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        StRun: begin
          if (en) begin
            // Select is decided from the counters before this cycle's update.
            if (m_cnt_q == MW'(1))          sel_d = SelInject;
            else if (n_wrap && !m_wrap)     sel_d = SelFeedback;
            else if (n_wrap && !clk_out_lvl) sel_d = SelHoldLow;

            if (n_wrap) begin
              n_cnt_d = NW'(1);
              if (m_wrap) begin
                m_cnt_d      = MW'(1);
                frame_done_d = 1'b1;
                if (cfg_ok) begin
                  n_act_d = n_cfg;
                  m_act_d = m_cfg;
                end else begin
                  cfg_err_d = 1'b1;
                end
              end else begin
                m_cnt_d = m_cnt_q + MW'(1);
              end
            end else begin
              n_cnt_d = n_cnt_q + NW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      n_act_q      <= '0;
      m_act_q      <= '0;
      n_cnt_q      <= '0;
      m_cnt_q      <= '0;
      sel_q        <= SelInject;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_act_q      <= n_act_d;
      m_act_q      <= m_act_d;
      n_cnt_q      <= n_cnt_d;
      m_cnt_q      <= m_cnt_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign sel        = sel_q;
  assign n_cnt      = n_cnt_q;
  assign m_cnt      = m_cnt_q;
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;
  assign busy       = (state_q == StRun);

endmodule

// File: tb/tb_fmdll_sel_seq.sv
// Scoreboard bench for fmdll_sel_seq: a behavioural model queues the expected outputs
// for every driven cycle; directed frame sequences are also checked against fixed values.
module tb_fmdll_sel_seq;

  logic       clk = 1'b0;
  logic       rst_n, en, stop, clk_out_lvl;
  logic [3:0] n_cfg;
  logic [1:0] m_cfg;
  logic [1:0] sel;
  logic [3:0] n_cnt;
  logic [1:0] m_cnt;
  logic       frame_done, cfg_err, busy;

  fmdll_sel_seq #(.NW(4), .MW(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .stop       (stop),
    .n_cfg      (n_cfg),
    .m_cfg      (m_cfg),
    .clk_out_lvl(clk_out_lvl),
    .sel        (sel),
    .n_cnt      (n_cnt),
    .m_cnt      (m_cnt),
    .frame_done (frame_done),
    .cfg_err    (cfg_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] n;
    logic [1:0] m;
    logic       fd;
    logic       err;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  logic       md_run = 1'b0;
  logic [3:0] md_nact = '0, md_n = '0;
  logic [1:0] md_mact = '0, md_m = '0;
  logic [1:0] md_sel = '0;
  logic       md_fd = 1'b0, md_err = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic i_rst, input logic i_en, input logic i_stop,
                            input logic [3:0] i_n, input logic [1:0] i_m, input logic i_lvl);
    logic [1:0] nsel;
    md_fd = 1'b0;
    if (!i_rst) begin
      md_run = 1'b0; md_nact = '0; md_mact = '0; md_n = '0; md_m = '0;
      md_sel = 2'b00; md_err = 1'b0;
    end else if (i_stop) begin
      md_run = 1'b0; md_n = '0; md_m = '0; md_sel = 2'b00;
    end else if (!md_run) begin
      if (i_en) begin
        if (i_n != 0 && i_m != 0) begin
          md_run = 1'b1; md_nact = i_n; md_mact = i_m;
          md_n = 4'd1; md_m = 2'd1; md_err = 1'b0;
        end else begin
          md_err = 1'b1;
        end
      end
    end else if (i_en) begin
      nsel = md_sel;
      if (md_m == 1) nsel = 2'b00;
      else if (md_n == md_nact && md_m != md_mact) nsel = 2'b10;
      else if (md_n == md_nact && md_m == md_mact && !i_lvl) nsel = 2'b01;
      if (md_n < md_nact) begin
        md_n = md_n + 4'd1;
      end else begin
        md_n = 4'd1;
        if (md_m < md_mact) begin
          md_m = md_m + 2'd1;
        end else begin
          md_m  = 2'd1;
          md_fd = 1'b1;
          if (i_n != 0 && i_m != 0) begin
            md_nact = i_n; md_mact = i_m;
          end else begin
            md_err = 1'b1;
          end
        end
      end
      md_sel = nsel;
    end
  endtask

  task automatic drive(input logic i_rst, input logic i_en, input logic i_stop,
                       input logic [3:0] i_n, input logic [1:0] i_m, input logic i_lvl);
    exp_t e, got;
    @(negedge clk);
    rst_n = i_rst; en = i_en; stop = i_stop; n_cfg = i_n; m_cfg = i_m; clk_out_lvl = i_lvl;
    model_step(i_rst, i_en, i_stop, i_n, i_m, i_lvl);
    e = '{sel: md_sel, n: md_n, m: md_m, fd: md_fd, err: md_err, busy: md_run};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check_eq("sb_sel",  32'(sel),        32'(got.sel));
    check_eq("sb_n",    32'(n_cnt),      32'(got.n));
    check_eq("sb_m",    32'(m_cnt),      32'(got.m));
    check_eq("sb_fd",   32'(frame_done), 32'(got.fd));
    check_eq("sb_err",  32'(cfg_err),    32'(got.err));
    check_eq("sb_busy", 32'(busy),       32'(got.busy));
  endtask

  logic [1:0] exp_sel033 [11];
  logic [1:0] sel_log    [11];
  logic       fd_log     [11];
  logic [1:0] held_sel;
  logic       early_big, late_big, seen_fd;

  initial begin
    exp_sel033 = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
    rst_n = 1'b0; en = 1'b0; stop = 1'b0; n_cfg = '0; m_cfg = '0; clk_out_lvl = 1'b0;

    // Reset state, with en and stop active to show reset overrides them
    drive(1'b0, 1'b1, 1'b1, 4'd3, 2'd3, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 4'd3, 2'd3, 1'b0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_sel",  32'(sel),  32'd0);

    // N=3, M=3 frame with clk_out_lvl low
    drive(1'b1, 1'b1, 1'b0, 4'd3, 2'd3, 1'b0);
    sel_log[0] = sel; fd_log[0] = frame_done;
    for (int c = 1; c <= 10; c++) begin
      drive(1'b1, 1'b1, 1'b0, 4'd3, 2'd3, 1'b0);
      sel_log[c] = sel; fd_log[c] = frame_done;
      if (c == 5) check_eq("f33_c5_nm", {n_cnt, 2'b00, m_cnt}, {4'd3, 2'b00, 2'd2});
      if (c == 8) check_eq("f33_c8_nm", {n_cnt, 2'b00, m_cnt}, {4'd3, 2'b00, 2'd3});
    end
    for (int c = 0; c <= 10; c++) check_eq($sformatf("f33_sel_c%0d", c), 32'(sel_log[c]),
                                           32'(exp_sel033[c]));
    check_eq("f33_fd_c8",  32'(fd_log[8]),  32'd0);
    check_eq("f33_fd_c9",  32'(fd_log[9]),  32'd1);
    check_eq("f33_fd_c10", 32'(fd_log[10]), 32'd0);

    // Same frame but clk_out_lvl high at the (3,3) cycle
    drive(1'b1, 1'b1, 1'b1, 4'd3, 2'd3, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 4'd3, 2'd3, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      drive(1'b1, 1'b1, 1'b0, 4'd3, 2'd3, (c == 9));
      if (c == 9)  check_eq("lvl_sel_c9",  32'(sel), 32'b10);
      if (c == 10) check_eq("lvl_sel_c10", 32'(sel), 32'b00);
    end

    // Invalid config from IDLE, then a valid one
    drive(1'b1, 1'b1, 1'b1, 4'd3, 2'd3, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 4'd0, 2'd3, 1'b0);
    check_eq("cfg0_err",  32'(cfg_err), 32'd1);
    check_eq("cfg0_busy", 32'(busy),    32'd0);
    check_eq("cfg0_sel",  32'(sel),     32'd0);
    drive(1'b1, 1'b1, 1'b0, 4'd2, 2'd3, 1'b0);
    check_eq("cfg2_busy", 32'(busy),    32'd1);
    check_eq("cfg2_err",  32'(cfg_err), 32'd0);

    // Mid-frame ratio change only takes effect after the frame wrap
    drive(1'b1, 1'b1, 1'b1, 4'd2, 2'd2, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 4'd2, 2'd2, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 4'd2, 2'd2, 1'b0);
    early_big = 1'b0; late_big = 1'b0; seen_fd = 1'b0;
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, 1'b1, 1'b0, 4'd5, 2'd2, 1'b0);
      if (frame_done) seen_fd = 1'b1;
      if (n_cnt > 4'd2) begin
        if (seen_fd) late_big = 1'b1;
        else early_big = 1'b1;
      end
    end
    check_eq("reload_early", 32'(early_big), 32'd0);
    check_eq("reload_late",  32'(late_big),  32'd1);

    // Freeze with en low at (2,2), then resume
    drive(1'b1, 1'b1, 1'b1, 4'd3, 2'd3, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 4'd3, 2'd3, 1'b0);
    for (int c = 1; c <= 4; c++) drive(1'b1, 1'b1, 1'b0, 4'd3, 2'd3, 1'b0);
    held_sel = sel;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 1'b0, 4'd3, 2'd3, 1'b0);
      check_eq("frz_nm",  {n_cnt, 2'b00, m_cnt}, {4'd2, 2'b00, 2'd2});
      check_eq("frz_sel", 32'(sel), 32'(held_sel));
    end
    drive(1'b1, 1'b1, 1'b0, 4'd3, 2'd3, 1'b0);
    check_eq("resume_nm", {n_cnt, 2'b00, m_cnt}, {4'd3, 2'b00, 2'd2});

    // Reset mid-RUN while sel=10
    drive(1'b1, 1'b1, 1'b0, 4'd3, 2'd3, 1'b0);
    check_eq("pre_rst_sel", 32'(sel), 32'b10);
    drive(1'b0, 1'b1, 1'b0, 4'd3, 2'd3, 1'b0);
    check_eq("midrst_all", {sel, n_cnt, m_cnt, frame_done, cfg_err, busy}, 32'd0);

    // Bad reload at wrap sets cfg_err; stop later keeps it
    drive(1'b1, 1'b1, 1'b0, 4'd3, 2'd3, 1'b0);
    for (int c = 1; c <= 15; c++) drive(1'b1, 1'b1, 1'b0, (c == 9) ? 4'd0 : 4'd3, 2'd3, 1'b0);
    check_eq("badrel_err", 32'(cfg_err), 32'd1);
    check_eq("badrel_sel", 32'(sel), 32'b10);
    drive(1'b1, 1'b1, 1'b1, 4'd3, 2'd3, 1'b0);
    check_eq("stop_all", {sel, n_cnt, m_cnt, frame_done, cfg_err, busy}, 32'b10);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      logic [3:0] rn;
      logic [1:0] rm;
      rn = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      rm = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 39) == 0), rn, rm, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
